// File: rtl/dpram_port_arbiter_if.sv
// Requester/RAM bundle for the dpram port arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface dpram_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    rd_req;
  logic [NREQ*AW-1:0] rd_addr;
  logic [NREQ-1:0]    rd_gnt;
  logic [NREQ-1:0]    rd_vld;
  logic [DW-1:0]      rd_data;
  logic [NREQ-1:0]    wr_req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*DW-1:0] wr_data;
  logic [NREQ-1:0]    wr_gnt;
  logic [AW-1:0]      ram_raddr;
  logic [DW-1:0]      ram_dout;
  logic               ram_we;
  logic [AW-1:0]      ram_waddr;
  logic [DW-1:0]      ram_din;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_dout,
    output rd_gnt, rd_vld, rd_data, wr_gnt,
    output ram_raddr, ram_we, ram_waddr, ram_din
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_dout,
    input  rd_gnt, rd_vld, rd_data, wr_gnt,
    input  ram_raddr, ram_we, ram_waddr, ram_din
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin sharing of one dpram read port and one write port
// between NREQ requesters, with optional write-to-read forwarding.
module dpram_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1,
  parameter int FWD    = 1
) (
  input logic clk,
  input logic rst,
  dpram_port_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic          hit;
    logic [PW-1:0] idx;
  } pick_t;

  function automatic pick_t pick(
    input logic [NREQ-1:0] req,
    input logic [PW-1:0]   ptr
  );
    pick_t         p;
    int            ix;
    logic [PW-1:0] ixs;
    p = '0;
    for (int k = 0; k < NREQ; k++) begin
      ix = int'(ptr) + k;
      if (ix >= NREQ) ix = ix - NREQ;
      ixs = PW'(ix);
      if (!p.hit && req[ixs]) begin
        p.hit = 1'b1;
        p.idx = ixs;
      end
    end
    return p;
  endfunction

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] idx
  );
    return (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  pick_t           rd_p;
  pick_t           wr_p;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_last;
  logic [PW-1:0]   wr_last;
  logic [PW-1:0]   rd_sel;
  logic [PW-1:0]   wr_sel;
  logic [NREQ-1:0] rd_gnt_c;
  logic [NREQ-1:0] wr_gnt_c;
  logic [AW-1:0]   raddr;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   din;
  logic            fwd_hit;

  // Rotating-priority pick; grants are forced off during reset.
  always_comb begin
    rd_p     = pick(bus.rd_req, rd_ptr);
    wr_p     = pick(bus.wr_req, wr_ptr);
    rd_gnt_c = '0;
    wr_gnt_c = '0;
    if (!rst && rd_p.hit) rd_gnt_c[rd_p.idx] = 1'b1;
    if (!rst && wr_p.hit) wr_gnt_c[wr_p.idx] = 1'b1;
    rd_sel = rd_p.hit ? rd_p.idx : rd_last;
    wr_sel = wr_p.hit ? wr_p.idx : wr_last;
  end

  // Address/data steering from the selected lane.
  always_comb begin
    raddr = '0;
    waddr = '0;
    din   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PW'(k) == rd_sel) raddr = bus.rd_addr[k*AW +: AW];
      if (PW'(k) == wr_sel) begin
        waddr = bus.wr_addr[k*AW +: AW];
        din   = bus.wr_data[k*DW +: DW];
      end
    end
  end

  assign fwd_hit = (FWD != 0) && (|rd_gnt_c) &&
                   (|wr_gnt_c) && (raddr == waddr);

  assign bus.rd_gnt    = rd_gnt_c;
  assign bus.wr_gnt    = wr_gnt_c;
  assign bus.ram_we    = |wr_gnt_c;
  assign bus.ram_raddr = raddr;
  assign bus.ram_waddr = waddr;
  assign bus.ram_din   = din;

  // Pointers move past each grant; last lane kept for idle muxing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rd_last <= '0;
      wr_last <= '0;
    end else begin
      if (rd_p.hit) begin
        rd_ptr  <= nxt(rd_p.idx);
        rd_last <= rd_p.idx;
      end
      if (wr_p.hit) begin
        wr_ptr  <= nxt(wr_p.idx);
        wr_last <= wr_p.idx;
      end
    end
  end

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign bus.rd_vld  = rd_gnt_c;
      assign bus.rd_data = fwd_hit ? din : bus.ram_dout;
    end else begin : g_lat1
      logic [NREQ-1:0] vld_q;
      logic            fwd_q;
      logic [DW-1:0]   fwd_d;

      // Valid and forwarded data line up with the RAM's registered dout.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          fwd_q <= 1'b0;
          fwd_d <= '0;
        end else begin
          vld_q <= rd_gnt_c;
          fwd_q <= fwd_hit;
          if (fwd_hit) fwd_d <= din;
        end
      end

      assign bus.rd_vld  = vld_q;
      assign bus.rd_data = fwd_q ? fwd_d : bus.ram_dout;
    end
  endgenerate

endmodule
